// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction-memory request/ack, the decode
// valid/ready channel with its halt flag, and the redirect channel.
interface pc_fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  // Sequencer side: drives memory requests and presents words to decode
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output instr_valid,
    output instr,
    input  instr_ready,
    input  halt,
    input  redirect_valid,
    input  redirect_target
  );

  // Environment side: memory, decode and branch resolution
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  instr_valid,
    input  instr,
    output instr_ready,
    output halt,
    output redirect_valid,
    output redirect_target
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Fetch controller for the PC register: chooses hold / increment / redirect
// each cycle, runs the imem request/ack handshake and hands fetched words to
// decode over valid/ready. A redirect that lands while a memory transaction
// is still outstanding marks that transaction stale so its data is dropped.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 pc_cur,
  output logic                        pc_load,
  output logic [31:0]                 pc_next,
  input  logic                        start,
  pc_fetch_sequencer_if.master        bus,
  output logic                        busy,
  output logic                        halted,
  output logic [31:0]                 instr_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] instr_q;
  logic [31:0] hold_addr;
  logic        discard;
  logic [31:0] count_q;
  logic        issue_take;

  // Decode accepts the presented word; a redirect suppresses the handshake
  assign issue_take  = (state == ISSUE) && !bus.redirect_valid && bus.instr_ready;
  assign instr_count = count_q;

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        if (bus.imem_ack && !discard && !bus.redirect_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (bus.redirect_valid) state_nxt = FETCH;
        else if (bus.instr_ready) state_nxt = bus.halt ? HALTED : FETCH;
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Captured instruction, stale-transaction tracking and accepted-instruction count
  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_q   <= 32'd0;
      hold_addr <= 32'd0;
      discard   <= 1'b0;
      count_q   <= 32'd0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.imem_ack) begin
            if (discard) discard <= 1'b0;
            else if (!bus.redirect_valid) instr_q <= bus.imem_rdata;
          end else if (bus.redirect_valid && !discard) begin
            hold_addr <= pc_cur;
            discard   <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue_take) count_q <= count_q + 32'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Bus outputs, status flags and the PC load strobe/value
  always_comb begin
    bus.imem_req    = 1'b0;
    bus.imem_addr   = discard ? hold_addr : pc_cur;
    bus.instr_valid = 1'b0;
    bus.instr       = instr_q;
    busy            = 1'b0;
    halted          = 1'b0;
    pc_load         = 1'b1;
    pc_next         = pc_cur;
    case (state)
      FETCH: begin
        bus.imem_req = 1'b1;
        busy         = 1'b1;
        if (bus.redirect_valid) pc_next = bus.redirect_target;
      end
      ISSUE: begin
        busy            = 1'b1;
        bus.instr_valid = !bus.redirect_valid;
        if (bus.redirect_valid) pc_next = bus.redirect_target;
        else if (bus.instr_ready && !bus.halt) pc_load = 1'b0;
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
    if (!rst) begin
      pc_load = 1'b1;
      pc_next = RESET_VEC;
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: a PC register and a
// variable-latency memory around the DUT, a transaction-level model checked
// every cycle, and directed scenarios with hand-computed expectations.
module tb_pc_fetch_sequencer;
  localparam logic [31:0] RV = 32'h0000_0040;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] pc_cur;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        busy;
  logic        halted;
  logic [31:0] instr_count;

  int vectors;
  int miscompares;
  int ack_delay;
  int wait_cnt;

  pc_fetch_sequencer_if bus ();

  pc_fetch_sequencer #(.RESET_VEC(RV)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_cur      (pc_cur),
    .pc_load     (pc_load),
    .pc_next     (pc_next),
    .start       (start),
    .bus         (bus),
    .busy        (busy),
    .halted      (halted),
    .instr_count (instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // PC register: loads pc_next when strobed, otherwise increments
  always @(posedge clk) begin
    pc_cur <= pc_load ? pc_next : pc_cur + 32'd1;
  end

  // Memory: acks after ack_delay cycles of continuous request
  always @(posedge clk) begin
    if (!rst || !bus.imem_req || bus.imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end
  assign bus.imem_ack   = bus.imem_req && (wait_cnt >= ack_delay);
  assign bus.imem_rdata = mem_word(bus.imem_addr);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic rdy, input logic h,
                               input logic rv, input logic [31:0] tgt);
    rst                 = r;
    start               = s;
    bus.instr_ready     = rdy;
    bus.halt            = h;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Transaction-level model: is the fetcher running, does it hold a word
  // for decode, is an outstanding memory transaction stale, and the PC.
  bit          model_on;
  bit          m_active;
  bit          m_word_held;
  bit          m_stopped;
  bit          m_stale;
  logic [31:0] m_stale_addr;
  logic [31:0] m_word;
  logic [31:0] m_count;
  logic [31:0] m_pc;
  bit          e_req;
  bit          e_valid;
  bit          e_load;
  logic [31:0] e_next;

  always @(negedge clk) begin
    e_req   = m_active && !m_word_held;
    e_valid = m_active && m_word_held && !bus.redirect_valid;
    e_load  = 1'b1;
    e_next  = m_pc;
    if (!rst) e_next = RV;
    else if (m_active && bus.redirect_valid) e_next = bus.redirect_target;
    else if (e_valid && bus.instr_ready && !bus.halt) e_load = 1'b0;

    if (model_on) begin
      checkOutput("cyc.pc_cur", pc_cur, m_pc);
      checkOutput("cyc.imem_req", {31'd0, bus.imem_req}, {31'd0, e_req});
      if (e_req) checkOutput("cyc.imem_addr", bus.imem_addr, m_stale ? m_stale_addr : m_pc);
      checkOutput("cyc.instr_valid", {31'd0, bus.instr_valid}, {31'd0, e_valid});
      checkOutput("cyc.instr", bus.instr, m_word);
      checkOutput("cyc.busy", {31'd0, busy}, {31'd0, m_active});
      checkOutput("cyc.halted", {31'd0, halted}, {31'd0, m_stopped});
      checkOutput("cyc.instr_count", instr_count, m_count);
      checkOutput("cyc.pc_load", {31'd0, pc_load}, {31'd0, e_load});
      if (e_load) checkOutput("cyc.pc_next", pc_next, e_next);
    end

    if (!rst) begin
      model_on    = 1'b1;
      m_active    = 1'b0;
      m_word_held = 1'b0;
      m_stopped   = 1'b0;
      m_stale     = 1'b0;
      m_stale_addr = 32'd0;
      m_word      = 32'd0;
      m_count     = 32'd0;
      m_pc        = RV;
    end else if (model_on) begin
      if (!m_active && !m_stopped) begin
        if (start) m_active = 1'b1;
      end else if (m_active && !m_word_held) begin
        if (bus.imem_ack) begin
          if (m_stale) m_stale = 1'b0;
          else if (!bus.redirect_valid) begin
            m_word      = mem_word(m_pc);
            m_word_held = 1'b1;
          end
        end else if (bus.redirect_valid && !m_stale) begin
          m_stale      = 1'b1;
          m_stale_addr = m_pc;
        end
      end else if (m_active && m_word_held) begin
        if (bus.redirect_valid) m_word_held = 1'b0;
        else if (bus.instr_ready) begin
          m_count     = m_count + 32'd1;
          m_word_held = 1'b0;
          if (bus.halt) begin
            m_active  = 1'b0;
            m_stopped = 1'b1;
          end
        end
      end
      m_pc = e_load ? e_next : m_pc + 32'd1;
    end
  end

  // Directed scenarios
  initial begin
    vectors     = 0;
    miscompares = 0;
    model_on    = 1'b0;
    ack_delay   = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;

    // Reset held two cycles, then idle with start low
    tick();
    tick();
    checkOutput("rst.pc_load", {31'd0, pc_load}, 32'd1);
    checkOutput("rst.pc_next", pc_next, 32'h40);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("idle.pc_cur", pc_cur, 32'h40);
      checkOutput("idle.imem_req", {31'd0, bus.imem_req}, 32'd0);
      checkOutput("idle.instr_valid", {31'd0, bus.instr_valid}, 32'd0);
      checkOutput("idle.busy", {31'd0, busy}, 32'd0);
      checkOutput("idle.halted", {31'd0, halted}, 32'd0);
      checkOutput("idle.instr_count", instr_count, 32'd0);
    end

    // Straight-line fetch with zero-wait memory
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 checkOutput("line.imem_addr", bus.imem_addr, 32'h40 + k);
      checkOutput("line.instr_valid_lo", {31'd0, bus.instr_valid}, 32'd0);
      tick();
      #1 checkOutput("line.instr_valid_hi", {31'd0, bus.instr_valid}, 32'd1);
      checkOutput("line.instr", bus.instr, mem_word(32'h40 + k));
      tick();
    end
    checkOutput("line.instr_count", instr_count, 32'd3);

    // Backpressure in ISSUE
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1 checkOutput("bp.instr", bus.instr, 32'hC0DE_0040);
      checkOutput("bp.imem_req", {31'd0, bus.imem_req}, 32'd0);
      checkOutput("bp.pc_load", {31'd0, pc_load}, 32'd1);
      checkOutput("bp.pc_next", pc_next, 32'h40);
      tick();
    end
    bus.instr_ready = 1'b1;
    tick();
    checkOutput("bp.pc_after", pc_cur, 32'h41);

    // Redirect during a delayed fetch
    doReset();
    ack_delay = 3;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100);
    #1 checkOutput("rdf.pc_next", pc_next, 32'h100);
    tick();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("rdf.imem_addr_old", bus.imem_addr, 32'h40);
      checkOutput("rdf.instr_valid", {31'd0, bus.instr_valid}, 32'd0);
      tick();
    end
    ack_delay = 0;
    #1 checkOutput("rdf.imem_addr_new", bus.imem_addr, 32'h100);
    tick();
    checkOutput("rdf.instr", bus.instr, mem_word(32'h100));

    // Second redirect while the stale transaction is still pending
    doReset();
    ack_delay = 2;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100);
    tick();
    bus.redirect_target = 32'h180;
    #1 checkOutput("rd2.imem_addr", bus.imem_addr, 32'h40);
    checkOutput("rd2.pc_next", pc_next, 32'h180);
    tick();
    bus.redirect_valid = 1'b0;
    #1 checkOutput("rd2.ack", {31'd0, bus.imem_ack}, 32'd1);
    tick();
    checkOutput("rd2.imem_addr_new", bus.imem_addr, 32'h180);

    // Redirect arriving with the ack, then redirect in ISSUE against ready
    doReset();
    ack_delay = 0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80);
    tick();
    bus.redirect_valid = 1'b0;
    #1 checkOutput("rda.imem_addr", bus.imem_addr, 32'h80);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100);
    #1 checkOutput("rdi.instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    checkOutput("rdi.instr_count", instr_count, 32'd0);
    checkOutput("rdi.imem_addr", bus.imem_addr, 32'h100);

    // Halt at PC 0x45, then ignored inputs, then reset out
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tick();
    end
    tick();
    bus.halt = 1'b1;
    #1 checkOutput("hlt.pc_next", pc_next, 32'h45);
    tick();
    bus.halt = 1'b0;
    checkOutput("hlt.halted", {31'd0, halted}, 32'd1);
    checkOutput("hlt.busy", {31'd0, busy}, 32'd0);
    checkOutput("hlt.instr_count", instr_count, 32'd6);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
    tick();
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("hlt.pc_kept", pc_cur, 32'h45);
    checkOutput("hlt.imem_req", {31'd0, bus.imem_req}, 32'd0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1 checkOutput("hlt.rst_halted", {31'd0, halted}, 32'd0);
    checkOutput("hlt.rst_pc", pc_cur, 32'h40);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Fetch-side controller for the program counter register. It decides every cycle whether the PC holds, advances by one word, or loads a redirect target. It runs the instruction-memory request/acknowledge handshake and hands fetched words to decode over a valid/ready interface. It drives the PC's load strobe and load value and reads the PC's current value back.

## Interface
- RESET_VEC, 32'h0000_0000, PC value loaded while reset is asserted
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- pc_cur  in  32  current PC value (PC register output)
- pc_load  out  1  PC load strobe (PC register `done`); 0 = PC increments by 1 this edge
- pc_next  out  32  PC load value (PC register `PC_in`)
- start  in  1  begin fetching; honoured only in IDLE
- imem_req  out  1  instruction-memory request
- imem_addr  out  32  word address, stable while imem_req=1 until imem_ack
- imem_ack  in  1  completes the current transaction; may arrive in the same cycle as the request
- imem_rdata  in  32  instruction word, valid with imem_ack
- instr_valid  out  1  instruction available to decode
- instr  out  32  instruction word to decode
- instr_ready  in  1  decode accepts instr
- halt  in  1  decode flags the presented instruction as HALT; sampled only on handshake
- redirect_valid  in  1  branch/jump resolved taken
- redirect_target  in  32  new PC
- busy  out  1  state is FETCH or ISSUE
- halted  out  1  state is HALTED
- instr_count  out  32  number of instructions accepted by decode, wraps modulo 2^32

## Operation
- States: IDLE, FETCH, ISSUE, HALTED. Registers: state, instr, hold_addr, discard, instr_count.
- pc_load and pc_next are combinational. The default is hold: pc_load=1, pc_next=pc_cur.
  - rst=0: pc_load=1, pc_next=RESET_VEC.
  - Increment: pc_load=0 only on an ISSUE handshake (instr_valid & instr_ready) with halt=0 and redirect_valid=0.
  - Redirect: in FETCH or ISSUE, redirect_valid=1 gives pc_load=1, pc_next=redirect_target. Redirect has priority over the increment.
- IDLE: imem_req=0, instr_valid=0. start=1 → FETCH. redirect_valid is ignored.
- FETCH: imem_req=1. imem_addr = (discard ? hold_addr : pc_cur).
  - imem_ack with discard=0 and redirect_valid=0: instr ← imem_rdata, go to ISSUE.
  - imem_ack with discard=1: drop data, clear discard, stay in FETCH. A new request starts next cycle at the redirected PC.
  - imem_ack and redirect_valid in the same cycle: drop data, stay in FETCH. discard stays 0 because the transaction is complete.
  - redirect_valid without ack while discard=0: hold_addr ← pc_cur, discard ← 1. A further redirect while discard=1 reloads the PC only; hold_addr is unchanged.
- ISSUE: instr_valid = ~redirect_valid, so a redirect suppresses the handshake combinationally.
  - Handshake: instr_count+1. halt=1 → HALTED with PC held; otherwise → FETCH with PC+1.
  - redirect_valid=1: instr dropped, → FETCH with PC=target. instr_count is unchanged.
  - instr_ready=0: instr stays stable and no new memory request is issued.
- HALTED: imem_req=0, instr_valid=0. PC is held. start, redirect_valid and halt are ignored. Only reset exits.
- Reset (rst=0 at an edge, from any state, including mid-transaction):
  - state=IDLE; instr, hold_addr, discard and instr_count all 0.
  - Outputs next cycle: imem_req=0, instr_valid=0, busy=0, halted=0.
  - An outstanding memory transaction is abandoned; the memory must tolerate this.

## Timing
- Zero-wait memory:
  - start sampled in cycle 0 → FETCH in cycle 1 (req+ack) → instr_valid in cycle 2.
  - Peak throughput is one instruction per 2 cycles.
- N-cycle ack delay adds N cycles in FETCH. imem_addr and imem_req stay stable throughout.
- PC changes only at the edge ending an increment or redirect cycle. pc_cur in the first FETCH cycle is the address being fetched.
- Redirect to the new fetch:
  - From ISSUE: the new request is issued the next cycle.
  - From FETCH with a pending transaction: the new request is issued the cycle after the old ack.

## Test plan
- Reset: RESET_VEC=32'h40, hold rst=0 for 2 cycles → pc_load=1, pc_next=0x40. After release: PC=0x40 and held while start=0; all outputs 0.
- Straight-line: imem_ack=1, instr_ready=1, pulse start → imem_addr 0x40, 0x41, 0x42 on alternate cycles. instr_valid is first high 2 cycles after start. instr_count=3 after the third handshake.
- Backpressure: instr_ready=0 for 5 cycles in ISSUE → instr stable, imem_req=0, pc_load=1 with pc_next=pc_cur throughout. Then ready=1 → PC 0x41.
- Redirect mid-fetch: ack delayed 3 cycles, redirect_valid with target 0x100 in the first FETCH cycle → imem_addr stays 0x40 until ack. The data is dropped (no instr_valid). The next request is to 0x100.
- Redirect in ISSUE with instr_ready=1 in the same cycle → instr_valid=0, instr_count unchanged, next imem_addr=0x100.
- Halt: handshake at PC 0x45 with halt=1 → halted=1, busy=0, PC stays 0x45. Later start and redirect pulses have no effect. rst=0 returns the block to IDLE with PC=RESET_VEC.
